configurable_multiplier_seq: RTL and testbench

Parametrised, iterative successor to the configurable multiplier: one WIDTH×WIDTH multiplier that can also run as one, two or four independent sub-width lanes, with per-transaction signed/unsigned selection. Operands enter through a valid/ready handshake. Each lane runs a radix-2 shift-add engine, one multiplier bit per cycle, so latency scales with lane width. Results leave through a valid/ready handshake with backpressure. The block sits between the operand sequencer and the accumulate stage of the datapath.

---
 rtl/cm_pkg.sv | 25 ++
 rtl/mult_lane_sa.sv | 37 +++
 rtl/configurable_multiplier_seq.sv | 158 +++++++++++++++
 tb/tb_configurable_multiplier_seq.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/cm_pkg.sv
// Shared definitions for the iterative configurable multiplier: lane modes,
// FSM state encoding and the mode-to-lane-width mapping.
package cm_pkg;

  localparam logic [1:0] CM_HALF = 2'b00;
  localparam logic [1:0] CM_DUAL = 2'b01;
  localparam logic [1:0] CM_FULL = 2'b10;
  localparam logic [1:0] CM_QUAD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIX,
    ST_DONE
  } state_t;

  function automatic int unsigned lane_width(input int unsigned width, input logic [1:0] mode);
    case (mode)
      CM_FULL: return width;
      CM_QUAD: return width / 4;
      default: return width / 2;
    endcase
  endfunction

endpackage

// File: rtl/mult_lane_sa.sv
// One radix-2 shift-add lane: unsigned LW x LW magnitudes, one multiplier
// bit consumed per step, exact 2*LW-bit result.
module mult_lane_sa #(
  parameter int unsigned LW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            step,
  input  logic [LW-1:0]   a,
  input  logic [LW-1:0]   b,
  output logic [2*LW-1:0] result
);

  logic [2*LW-1:0] acc;
  logic [2*LW-1:0] mcand;
  logic [LW-1:0]   mplier;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (start) begin
      acc    <= '0;
      mcand  <= {{LW{1'b0}}, a};
      mplier <= b;
    end else if (step) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

  assign result = acc;

endmodule

// File: rtl/configurable_multiplier_seq.sv
// Iterative configurable multiplier: one full, two half or four quarter-width
// shift-add lanes, sign-magnitude handling around unsigned engines.
module configurable_multiplier_seq
  import cm_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               enable_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [1:0]         cm_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   multiplicand_i,
  input  logic [WIDTH-1:0]   multiplier_i,
  output logic [2*WIDTH-1:0] product_o,
  output logic               valid_o,
  input  logic               ready_i
);

  localparam int unsigned HW = WIDTH / 2;
  localparam int unsigned QW = WIDTH / 4;
  localparam int unsigned CW = $clog2(WIDTH) + 1;

  state_t           state;
  logic [1:0]       mode;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    len;
  logic             accept;
  logic             calc_step;
  logic             step_full, step_dual, step_quad;

  logic             sgn_full_d, neg_full;
  logic [1:0]       sgn_dual_d, neg_dual;
  logic [3:0]       sgn_quad_d, neg_quad;

  logic [2*WIDTH-1:0] res_full;
  logic [2*WIDTH-1:0] res_dual;
  logic [2*WIDTH-1:0] res_quad;
  logic [2*WIDTH-1:0] fix_prod;

  assign ready_o   = (state == ST_IDLE) && enable_i && !rst_i;
  assign accept    = valid_i && ready_o;
  assign calc_step = enable_i && (state == ST_CALC);
  assign step_full = calc_step && (mode == CM_FULL);
  assign step_dual = calc_step && ((mode == CM_DUAL) || (mode == CM_HALF));
  assign step_quad = calc_step && (mode == CM_QUAD);

  // Every group is loaded on accept; only the latched group is stepped.
  if (1) begin : g_full
    logic [WIDTH-1:0] ma, mb;
    logic             sa, sb;
    assign sa = signed_i & multiplicand_i[WIDTH-1];
    assign sb = signed_i & multiplier_i[WIDTH-1];
    assign sgn_full_d = sa ^ sb;
    assign ma = sa ? ('0 - multiplicand_i) : multiplicand_i;
    assign mb = sb ? ('0 - multiplier_i) : multiplier_i;
    mult_lane_sa #(.LW(WIDTH)) u_lane (
      .clk(clk_i), .rst(rst_i), .start(accept), .step(step_full),
      .a(ma), .b(mb), .result(res_full)
    );
  end

  for (genvar k = 0; k < 2; k++) begin : g_dual
    logic [HW-1:0] a, b, ma, mb;
    logic          sa, sb;
    assign a  = multiplicand_i[k*HW +: HW];
    assign b  = multiplier_i[k*HW +: HW];
    assign sa = signed_i & a[HW-1];
    assign sb = signed_i & b[HW-1];
    assign sgn_dual_d[k] = sa ^ sb;
    assign ma = sa ? ('0 - a) : a;
    assign mb = sb ? ('0 - b) : b;
    mult_lane_sa #(.LW(HW)) u_lane (
      .clk(clk_i), .rst(rst_i), .start(accept), .step(step_dual),
      .a(ma), .b(mb), .result(res_dual[k*2*HW +: 2*HW])
    );
  end

  for (genvar k = 0; k < 4; k++) begin : g_quad
    logic [QW-1:0] a, b, ma, mb;
    logic          sa, sb;
    assign a  = multiplicand_i[k*QW +: QW];
    assign b  = multiplier_i[k*QW +: QW];
    assign sa = signed_i & a[QW-1];
    assign sb = signed_i & b[QW-1];
    assign sgn_quad_d[k] = sa ^ sb;
    assign ma = sa ? ('0 - a) : a;
    assign mb = sb ? ('0 - b) : b;
    mult_lane_sa #(.LW(QW)) u_lane (
      .clk(clk_i), .rst(rst_i), .start(accept), .step(step_quad),
      .a(ma), .b(mb), .result(res_quad[k*2*QW +: 2*QW])
    );
  end

  // Sign restore per lane; lanes outside the latched mode stay zero.
  always_comb begin
    fix_prod = '0;
    case (mode)
      CM_FULL: fix_prod = neg_full ? ('0 - res_full) : res_full;
      CM_HALF:
        fix_prod[2*HW-1:0] = neg_dual[0] ? ('0 - res_dual[2*HW-1:0]) : res_dual[2*HW-1:0];
      CM_DUAL:
        for (int unsigned k = 0; k < 2; k++)
          fix_prod[k*2*HW +: 2*HW] = neg_dual[k] ? ('0 - res_dual[k*2*HW +: 2*HW])
                                                 : res_dual[k*2*HW +: 2*HW];
      CM_QUAD:
        for (int unsigned k = 0; k < 4; k++)
          fix_prod[k*2*QW +: 2*QW] = neg_quad[k] ? ('0 - res_quad[k*2*QW +: 2*QW])
                                                 : res_quad[k*2*QW +: 2*QW];
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= ST_IDLE;
      mode      <= CM_HALF;
      cnt       <= '0;
      len       <= '0;
      neg_full  <= 1'b0;
      neg_dual  <= '0;
      neg_quad  <= '0;
      product_o <= '0;
      valid_o   <= 1'b0;
    end else if (enable_i) begin
      case (state)
        ST_IDLE: begin
          if (valid_i) begin
            mode     <= cm_i;
            len      <= CW'(lane_width(WIDTH, cm_i));
            neg_full <= sgn_full_d;
            neg_dual <= sgn_dual_d;
            neg_quad <= sgn_quad_d;
            cnt      <= '0;
            state    <= ST_CALC;
          end
        end
        ST_CALC: begin
          cnt <= cnt + CW'(1);
          if (cnt == len - CW'(1)) state <= ST_FIX;
        end
        ST_FIX: begin
          product_o <= fix_prod;
          valid_o   <= 1'b1;
          state     <= ST_DONE;
        end
        ST_DONE: begin
          if (ready_i) begin
            valid_o <= 1'b0;
            state   <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_configurable_multiplier_seq.sv
// Directed bench for configurable_multiplier_seq at WIDTH=16.
module tb_configurable_multiplier_seq;

  logic        clk = 1'b0;
  logic        rst_i, enable_i, valid_i, ready_o, signed_i, valid_o, ready_i;
  logic [1:0]  cm_i;
  logic [15:0] multiplicand_i, multiplier_i;
  logic [31:0] product_o;
  logic [31:0] held;
  logic        saw_valid;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  configurable_multiplier_seq #(.WIDTH(16)) dut (
    .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i), .valid_i(valid_i),
    .ready_o(ready_o), .cm_i(cm_i), .signed_i(signed_i),
    .multiplicand_i(multiplicand_i), .multiplier_i(multiplier_i),
    .product_o(product_o), .valid_o(valid_o), .ready_i(ready_i)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with ready_o high; returns at the negedge after the
  // accept edge with inputs scrambled so late changes would be visible.
  task automatic send(input logic [1:0] cm, input logic s, input logic [15:0] a, input logic [15:0] b);
    cm_i = cm; signed_i = s; multiplicand_i = a; multiplier_i = b; valid_i = 1'b1;
    chk("ready_before_accept", ready_o, 1'b1);
    @(negedge clk);
    valid_i = 1'b0; cm_i = ~cm; signed_i = ~s; multiplicand_i = ~a; multiplier_i = ~b;
  endtask

  task automatic wait_valid(input string tag, input int lat0, input int exp_lat, input logic [31:0] exp_prod);
    int lat = lat0;
    while (valid_o !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_product"}, product_o, exp_prod);
  endtask

  task automatic drain(input string tag);
    @(negedge clk);
    chk({tag, "_valid_cleared"}, valid_o, 1'b0);
    chk({tag, "_ready_back"}, ready_o, 1'b1);
  endtask

  initial begin
    rst_i = 1'b1; enable_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1;
    cm_i = 2'b00; signed_i = 1'b0; multiplicand_i = '0; multiplier_i = '0;
    repeat (2) @(negedge clk);
    chk("rst_product", product_o, 32'h0);
    chk("rst_valid", valid_o, 1'b0);
    chk("rst_ready", ready_o, 1'b0);
    rst_i = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", ready_o, 1'b1);

    send(2'b10, 1'b0, 16'h808D, 16'h0104);
    wait_valid("full_unsigned", 0, 17, 32'h00828F34);
    drain("full_unsigned");

    // Reset mid-idle must clear the previously held product.
    rst_i = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_rst_product", product_o, 32'h0);
    chk("idle_rst_valid", valid_o, 1'b0);
    chk("idle_rst_ready", ready_o, 1'b0);
    rst_i = 1'b0;
    @(negedge clk);
    chk("idle_rst_ready_release", ready_o, 1'b1);

    send(2'b01, 1'b1, 16'h808D, 16'h0104);
    wait_valid("dual_signed", 0, 9, 32'hFF80FE34);
    drain("dual_signed");

    send(2'b01, 1'b0, 16'h808D, 16'h0104);
    wait_valid("dual_unsigned", 0, 9, 32'h00800234);
    drain("dual_unsigned");

    send(2'b00, 1'b0, 16'h808D, 16'h0104);
    wait_valid("half_unsigned", 0, 9, 32'h00000234);
    drain("half_unsigned");

    send(2'b11, 1'b1, 16'h8F21, 16'h8F3A);
    wait_valid("quad_signed", 0, 5, 32'h400106FA);
    drain("quad_signed");

    send(2'b01, 1'b1, 16'h8080, 16'h8080);
    wait_valid("dual_most_negative", 0, 9, 32'h40004000);
    drain("dual_most_negative");

    // Backpressure with a competing request waiting.
    ready_i = 1'b0;
    send(2'b11, 1'b1, 16'h8F21, 16'h8F3A);
    wait_valid("bp_first", 0, 5, 32'h400106FA);
    held = product_o;
    cm_i = 2'b01; signed_i = 1'b0; multiplicand_i = 16'h808D; multiplier_i = 16'h0104;
    valid_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_valid_held", valid_o, 1'b1);
      chk("bp_product_held", product_o, held);
      chk("bp_ready_low", ready_o, 1'b0);
    end
    ready_i = 1'b1;
    @(negedge clk);
    chk("bp_released_valid", valid_o, 1'b0);
    chk("bp_released_ready", ready_o, 1'b1);
    @(negedge clk);
    valid_i = 1'b0;
    wait_valid("bp_second", 0, 9, 32'h00800234);
    drain("bp_second");

    // Reset five cycles into full-mode CALC aborts the transaction.
    send(2'b10, 1'b0, 16'h808D, 16'h0104);
    repeat (5) @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    saw_valid = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (valid_o === 1'b1) saw_valid = 1'b1;
    end
    chk("abort_no_valid", saw_valid, 1'b0);
    chk("abort_ready", ready_o, 1'b1);

    // Three stalled cycles mid-CALC stretch full latency from 17 to 20.
    send(2'b10, 1'b0, 16'h808D, 16'h0104);
    repeat (3) @(negedge clk);
    enable_i = 1'b0;
    repeat (3) @(negedge clk);
    enable_i = 1'b1;
    wait_valid("stall_full", 6, 20, 32'h00828F34);
    drain("stall_full");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
